// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin sharing of one pipelined 8-bit ALU by two requesters.
// Optional saturating grant counters are built when ALU_ARB_STATS_EN is defined.
module alu_rr_arbiter #(
    parameter int ALU_LAT = 2
`ifdef ALU_ARB_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [7:0]       req0_a,
    input  logic [7:0]       req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [7:0]       req1_a,
    input  logic [7:0]       req1_b,
    input  logic [1:0]       req1_op,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [1:0]       alu_c,
    input  logic [7:0]       alu_res,
    input  logic             alu_cout,
    input  logic             alu_valid,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    output logic [7:0]       rsp_data,
    output logic             rsp_cout,
    input  logic             quiesce,
    output logic             quiesced,
    output logic             busy,
`ifdef ALU_ARB_STATS_EN
    input  logic             stats_clr,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1,
`endif
    output logic             err
);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        QUIET
    } state_t;

    typedef struct packed {
        logic v;
        logic id;
    } tag_t;

    state_t state_q;
    state_t state_d;
    tag_t   tag_q [ALU_LAT+1];
    tag_t   head;
    logic   last_q;
    logic   err_q;
    logic   arb_en;
    logic   gnt0;
    logic   gnt1;
    logic   hs;
    logic   head_fault;

    // Round-robin grant; the requester not served last wins a tie
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (arb_en) begin
            if (req0_valid && req1_valid) begin
                gnt0 = last_q;
                gnt1 = ~last_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign hs         = gnt0 | gnt1;

    // Register the granted operation onto the ALU; bubbles drive zeros
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_c  <= '0;
            last_q <= 1'b1;
        end else if (gnt0) begin
            alu_a  <= req0_a;
            alu_b  <= req0_b;
            alu_c  <= req0_op;
            last_q <= 1'b0;
        end else if (gnt1) begin
            alu_a  <= req1_a;
            alu_b  <= req1_b;
            alu_c  <= req1_op;
            last_q <= 1'b1;
        end else begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_c  <= '0;
        end
    end

    // Tag shift register mirrors the ALU pipeline plus the operand register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= ALU_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0].v  <= hs;
            tag_q[0].id <= gnt1;
            for (int i = 0; i < ALU_LAT; i++) begin
                tag_q[i+1] <= tag_q[i];
            end
        end
    end

    // Any live tag means work is still in flight
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i <= ALU_LAT; i++) begin
            busy = busy | tag_q[i].v;
        end
    end

    assign head       = tag_q[ALU_LAT];
    assign head_fault = head.v & ~alu_valid;
    assign rsp0_valid = head.v & alu_valid & ~head.id;
    assign rsp1_valid = head.v & alu_valid & head.id;
    assign rsp_data   = alu_res;
    assign rsp_cout   = alu_cout;

    // Sticky record of a result slot the ALU failed to fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (head_fault) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q | head_fault;

    // Quiesce state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Quiesce next state; issue stops the cycle quiesce is seen
    always_comb begin
        state_d  = state_q;
        arb_en   = 1'b0;
        quiesced = 1'b0;
        unique case (state_q)
            RUN: begin
                arb_en = ~quiesce;
                if (quiesce) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!quiesce) begin
                    state_d = RUN;
                end else if (!busy) begin
                    state_d = QUIET;
                end
            end
            QUIET: begin
                quiesced = 1'b1;
                if (!quiesce) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

`ifdef ALU_ARB_STATS_EN
    // Saturating grant counters; a clear overrides a same-cycle grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (stats_clr) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (gnt0 && (grant_cnt0 != '1)) begin
                grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            end
            if (gnt1 && (grant_cnt1 != '1)) begin
                grant_cnt1 <= grant_cnt1 + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: randomized and directed bench for alu_rr_arbiter.
// Covers ALU_ARB_STATS_EN counters when that macro is defined.
module tb_alu_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0;
    logic       req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0] req0_op = '0, req1_op = '0;
    logic [7:0] alu_a, alu_b, alu_res;
    logic [1:0] alu_c;
    logic       alu_cout;
    logic       alu_ok = 1'b1;
    logic       rsp0_valid, rsp1_valid, rsp_cout;
    logic [7:0] rsp_data;
    logic       quiesce = 1'b0;
    logic       quiesced, busy, err;
`ifdef ALU_ARB_STATS_EN
    logic       stats_clr = 1'b0;
    logic [1:0] grant_cnt0, grant_cnt1;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    alu_rr_arbiter #(
        .ALU_LAT(2)
`ifdef ALU_ARB_STATS_EN
        ,
        .CNT_W(2)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
        .alu_res(alu_res), .alu_cout(alu_cout), .alu_valid(alu_ok),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp_data(rsp_data), .rsp_cout(rsp_cout),
        .quiesce(quiesce), .quiesced(quiesced), .busy(busy),
`ifdef ALU_ARB_STATS_EN
        .stats_clr(stats_clr),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
`endif
        .err(err)
    );

    // Two-stage external ALU, reset active-high
    logic [8:0] s1, s2;
    wire        alu_rst = ~rst_n;
    always_ff @(posedge clk or posedge alu_rst) begin
        if (alu_rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            case (alu_c)
                2'b00: s1 <= {1'b0, alu_a} + {1'b0, alu_b};
                2'b01: s1 <= {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
                2'b10: s1 <= {1'b0, alu_a & alu_b};
                default: s1 <= {1'b0, alu_a ^ alu_b};
            endcase
            s2 <= s1;
        end
    end
    assign alu_res  = s2[7:0];
    assign alu_cout = s2[8];

    // Reference model
    typedef struct {
        int         due;
        bit         id;
        logic [7:0] d;
        bit         c;
    } exp_t;

    exp_t       q[$];
    bit         m_last;
    int         m_st;
    bit         m_err;
    logic [7:0] m_a, m_b;
    logic [1:0] m_c;

    function automatic void m_reset();
        q.delete();
        m_last = 1'b1;
        m_st = 0;
        m_err = 1'b0;
        m_a = '0;
        m_b = '0;
        m_c = '0;
        cyc = 0;
    endfunction

    function automatic void calc(input int a, input int b, input int op,
                                 output logic [7:0] d, output bit c);
        int r;
        c = 1'b0;
        case (op)
            0: begin r = a + b; c = (r > 255); end
            1: begin r = a - b; c = (a >= b); end
            2: r = a & b;
            default: r = a ^ b;
        endcase
        d = 8'(r & 255);
    endfunction

    function automatic void e_grant(output bit g0, output bit g1);
        bit en;
        en = (m_st == 0) && !quiesce;
        g0 = 1'b0;
        g1 = 1'b0;
        if (en && req0_valid && req1_valid) begin
            if (m_last) g0 = 1'b1;
            else g1 = 1'b1;
        end else if (en) begin
            g0 = req0_valid;
            g1 = req1_valid;
        end
    endfunction

    function automatic bit e_rsp(input bit id);
        return q.size() > 0 && q[0].due == cyc && q[0].id == id && alu_ok;
    endfunction

    function automatic bit e_busy();
        foreach (q[i]) if (q[i].due - 2 <= cyc) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit e_err();
        return m_err || (q.size() > 0 && q[0].due == cyc && !alu_ok);
    endfunction

    task automatic advance();
        bit   g0, g1, bz;
        exp_t e;
        e_grant(g0, g1);
        bz = e_busy();
        if (q.size() > 0 && q[0].due == cyc) begin
            if (!alu_ok) m_err = 1'b1;
            void'(q.pop_front());
        end
        m_a = '0;
        m_b = '0;
        m_c = '0;
        if (g0 || g1) begin
            e.due = cyc + 3;
            e.id = g1;
            m_a = g1 ? req1_a : req0_a;
            m_b = g1 ? req1_b : req0_b;
            m_c = g1 ? req1_op : req0_op;
            calc(int'(m_a), int'(m_b), int'(m_c), e.d, e.c);
            q.push_back(e);
            m_last = g1;
        end
        case (m_st)
            0: if (quiesce) m_st = 1;
            1: if (!quiesce) m_st = 0; else if (!bz) m_st = 2;
            default: if (!quiesce) m_st = 0;
        endcase
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        quiesce = 1'b0;
        alu_ok = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
`ifdef ALU_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if ({alu_a, alu_b, alu_c} !== 18'h0) begin
            failures++;
            $display("FAIL reset_alu got=%h/%h/%h exp=0", alu_a, alu_b, alu_c);
        end
        checks++;
        if ({busy, err, quiesced, rsp0_valid, rsp1_valid} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {busy, err, quiesced, rsp0_valid, rsp1_valid});
        end
        do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            failures++;
            $display("FAIL reset_first_grant got=%b exp=10", {req0_ready, req1_ready});
        end
        advance();
        idle_inputs();
        repeat (4) advance();
    endtask

    task automatic test_single_op();
        req0_valid = 1'b1;
        req0_a = 8'h0F;
        req0_b = 8'h01;
        req0_op = 2'b00;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            failures++;
            $display("FAIL single_ready got=%b exp=10", {req0_ready, req1_ready});
        end
        advance();
        req0_valid = 1'b0;
        #1;
        checks++;
        if ({alu_a, alu_b, alu_c, busy} !== {8'h0F, 8'h01, 2'b00, 1'b1}) begin
            failures++;
            $display("FAIL single_issue got=%h/%h/%h busy=%b exp=0f/01/0 busy=1",
                     alu_a, alu_b, alu_c, busy);
        end
        advance();
        #1;
        checks++;
        if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
            failures++;
            $display("FAIL single_early got=%b exp=00", {rsp0_valid, rsp1_valid});
        end
        advance();
        #1;
        checks++;
        if ({rsp0_valid, rsp1_valid, rsp_data, rsp_cout} !== {2'b10, 8'h10, 1'b0}) begin
            failures++;
            $display("FAIL single_rsp got=%b %h c=%b exp=10 10 c=0",
                     {rsp0_valid, rsp1_valid}, rsp_data, rsp_cout);
        end
        advance();
        #1;
        checks++;
        if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
            failures++;
            $display("FAIL single_after got=%b exp=000", {rsp0_valid, rsp1_valid, busy});
        end
    endtask

    task automatic test_contention();
        bit       w0, rs0;
        logic [7:0] ed;
        do_reset();
        req0_a = 8'h05; req0_b = 8'h07; req0_op = 2'b01;
        req1_a = 8'hF0; req1_b = 8'hFF; req1_op = 2'b11;
        for (int k = 0; k < 9; k++) begin
            req0_valid = (k < 6);
            req1_valid = (k < 6);
            #1;
            if (k < 6) begin
                w0 = (k % 2 == 0);
                checks++;
                if ({req0_ready, req1_ready} !== {w0, !w0}) begin
                    failures++;
                    $display("FAIL cont_grant k=%0d got=%b exp=%b",
                             k, {req0_ready, req1_ready}, {w0, !w0});
                end
            end
            if (k >= 3) begin
                rs0 = ((k - 3) % 2 == 0);
                ed = rs0 ? 8'hFE : 8'h0F;
                checks++;
                if ({rsp0_valid, rsp1_valid, rsp_data, rsp_cout} !== {rs0, !rs0, ed, 1'b0}) begin
                    failures++;
                    $display("FAIL cont_rsp k=%0d got=%b %h c=%b exp=%b %h c=0",
                             k, {rsp0_valid, rsp1_valid}, rsp_data, rsp_cout,
                             {rs0, !rs0}, ed);
                end
            end
            advance();
        end
    endtask

    task automatic test_drain();
        int pulses;
        bit seen;
        pulses = 0;
        seen = 1'b0;
        req1_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req1_a = 8'($urandom);
            req1_b = 8'($urandom);
            req1_op = 2'($urandom_range(0, 3));
            #1;
            checks++;
            if (req1_ready !== 1'b1) begin
                failures++;
                $display("FAIL drain_issue k=%0d got=%b exp=1", k, req1_ready);
            end
            advance();
        end
        quiesce = 1'b1;
        for (int n = 0; n < 20 && !seen; n++) begin
            #1;
            checks++;
            if (quiesced !== (m_st == 2)) begin
                failures++;
                $display("FAIL drain_quiesced n=%0d got=%b exp=%b", n, quiesced, m_st == 2);
            end
            if (quiesced) begin
                seen = 1'b1;
            end else begin
                checks++;
                if ({req0_ready, req1_ready} !== 2'b00 || rsp1_valid !== e_rsp(1)) begin
                    failures++;
                    $display("FAIL drain_cycle n=%0d rdy=%b rsp1=%b exp rdy=00 rsp1=%b",
                             n, {req0_ready, req1_ready}, rsp1_valid, e_rsp(1));
                end
                if (rsp1_valid && e_rsp(1)) begin
                    pulses++;
                    checks++;
                    if ({rsp_data, rsp_cout} !== {q[0].d, q[0].c}) begin
                        failures++;
                        $display("FAIL drain_data got=%h/%b exp=%h/%b",
                                 rsp_data, rsp_cout, q[0].d, q[0].c);
                    end
                end
                advance();
            end
        end
        checks++;
        if (!seen || pulses != 3 || busy !== 1'b0) begin
            failures++;
            $display("FAIL drain_done seen=%b pulses=%0d busy=%b exp 1/3/0",
                     seen, pulses, busy);
        end
        quiesce = 1'b0;
        advance();
        #1;
        checks++;
        if ({quiesced, req1_ready} !== 2'b01) begin
            failures++;
            $display("FAIL drain_resume got=%b exp=01", {quiesced, req1_ready});
        end
        advance();
        req1_valid = 1'b0;
        repeat (4) advance();
    endtask

    task automatic test_random();
        bit g0, g1, r0, r1;
        for (int n = 0; n < 400; n++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_a = 8'($urandom);
            req0_b = 8'($urandom);
            req0_op = 2'($urandom_range(0, 3));
            req1_a = 8'($urandom);
            req1_b = 8'($urandom);
            req1_op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) quiesce = !quiesce;
            #1;
            e_grant(g0, g1);
            r0 = e_rsp(0);
            r1 = e_rsp(1);
            checks++;
            if ({req0_ready, req1_ready} !== {g0, g1}) begin
                failures++;
                $display("FAIL rnd_grant cyc=%0d got=%b exp=%b",
                         cyc, {req0_ready, req1_ready}, {g0, g1});
            end
            checks++;
            if ({rsp0_valid, rsp1_valid} !== {r0, r1}) begin
                failures++;
                $display("FAIL rnd_rsp cyc=%0d got=%b exp=%b",
                         cyc, {rsp0_valid, rsp1_valid}, {r0, r1});
            end
            if (r0 || r1) begin
                checks++;
                if ({rsp_data, rsp_cout} !== {q[0].d, q[0].c}) begin
                    failures++;
                    $display("FAIL rnd_data cyc=%0d got=%h/%b exp=%h/%b",
                             cyc, rsp_data, rsp_cout, q[0].d, q[0].c);
                end
            end
            checks++;
            if ({alu_a, alu_b, alu_c} !== {m_a, m_b, m_c}) begin
                failures++;
                $display("FAIL rnd_alu cyc=%0d got=%h/%h/%h exp=%h/%h/%h",
                         cyc, alu_a, alu_b, alu_c, m_a, m_b, m_c);
            end
            checks++;
            if ({busy, quiesced, err} !== {e_busy(), m_st == 2, e_err()}) begin
                failures++;
                $display("FAIL rnd_status cyc=%0d got=%b exp=%b",
                         cyc, {busy, quiesced, err}, {e_busy(), m_st == 2, e_err()});
            end
            advance();
        end
        idle_inputs();
        repeat (6) advance();
    endtask

    task automatic test_reset_midflight();
        req0_valid = 1'b1;
        req0_a = 8'h11; req0_b = 8'h22; req0_op = 2'b00;
        advance();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_a = 8'hA5; req1_b = 8'h5A; req1_op = 2'b10;
        advance();
        req1_valid = 1'b0;
        #1;
        checks++;
        if (alu_a !== 8'hA5 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre got=%h busy=%b exp=a5 busy=1", alu_a, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({alu_a, alu_b, alu_c, busy, rsp0_valid, rsp1_valid} !== 21'h0) begin
            failures++;
            $display("FAIL mid_reset got=%h/%h/%h busy=%b rsp=%b exp=0",
                     alu_a, alu_b, alu_c, busy, {rsp0_valid, rsp1_valid});
        end
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
                failures++;
                $display("FAIL mid_after k=%0d got=%b exp=000",
                         k, {rsp0_valid, rsp1_valid, busy});
            end
            advance();
        end
    endtask

`ifdef ALU_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        req0_valid = 1'b1;
        repeat (5) advance();
        #1;
        checks++;
        if ({grant_cnt0, grant_cnt1} !== 4'b1100) begin
            failures++;
            $display("FAIL stats_sat got=%b/%b exp=11/00", grant_cnt0, grant_cnt1);
        end
        stats_clr = 1'b1;
        advance();
        stats_clr = 1'b0;
        #1;
        checks++;
        if (grant_cnt0 !== 2'b00) begin
            failures++;
            $display("FAIL stats_clr got=%b exp=00", grant_cnt0);
        end
        advance();
        req0_valid = 1'b0;
        #1;
        checks++;
        if (grant_cnt0 !== 2'b01) begin
            failures++;
            $display("FAIL stats_inc got=%b exp=01", grant_cnt0);
        end
        repeat (4) advance();
    endtask
`endif

    task automatic test_alu_fault();
        do_reset();
        req0_valid = 1'b1;
        req0_a = 8'h01; req0_b = 8'h02; req0_op = 2'b00;
        advance();
        req0_valid = 1'b0;
        advance();
        #1;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL fault_pre got=%b exp=0", err);
        end
        advance();
        alu_ok = 1'b0;
        #1;
        checks++;
        if ({err, rsp0_valid, rsp1_valid} !== 3'b100) begin
            failures++;
            $display("FAIL fault_head got=%b exp=100", {err, rsp0_valid, rsp1_valid});
        end
        advance();
        alu_ok = 1'b1;
        repeat (3) advance();
        #1;
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL fault_sticky got=%b exp=1", err);
        end
        do_reset();
        #1;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL fault_clear got=%b exp=0", err);
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_contention();
        test_drain();
        test_random();
        test_reset_midflight();
`ifdef ALU_ARB_STATS_EN
        test_stats();
`endif
        test_alu_fault();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
